toast_data_mem: RTL and testbench
=================================

# toast_data_mem

Data-side memory responder for the Toast RV32I core. It sits on the far end of the core's MEM-stage port (mem_addr / mem_wr_data / mem_wr_en / mem_rst → mem_rd_data) and holds a word-organised data RAM plus a small memory-mapped register window. The window provides a halt/tohost mailbox for simulation and formal benches, a 64-bit cycle counter, and a scratch register. Reads are registered with one-cycle latency, which matches the core's MEM→WB timing.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, 16..65536.
- MMIO_BASE, 32'h8000_0000: base of the register window; decoded on mem_addr[31:4].
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- mem_addr  input  32  byte address from core; bits [1:0] ignored
- mem_wr_data  input  32  write data, full word
- mem_wr_en  input  1  write strobe, one write per cycle asserted
- mem_rst  input  1  synchronous clear of the read-data register
- mem_rd_data  output  32  registered read data
- halt  output  1  sticky; set by any write to TOHOST
- tohost  output  32  last value written to TOHOST
- err_oor  output  1  sticky; set by any access outside both the RAM and the register window

## Operation
- Decode on mem_addr:
  - RAM when mem_addr[31:2] < DEPTH_WORDS. Word index = mem_addr[$clog2(DEPTH_WORDS)+1:2].
  - Register window when mem_addr[31:4] == MMIO_BASE[31:4].
  - Otherwise out-of-range (OOR).
- Register window offsets (mem_addr[3:2]):
  - 0 TOHOST: read returns tohost. A write loads tohost and sets halt.
  - 1 CYCLE_LO: read returns cycle[31:0] and loads hi_snap ← cycle[63:32] on the same edge. Writes ignored.
  - 2 CYCLE_HI: read returns hi_snap. Writes ignored.
  - 3 SCRATCH: read/write, 32-bit.
- Reads occur every cycle; there is no read enable. mem_rd_data ← decoded data for the mem_addr present at the edge.
- Writes occur when mem_wr_en = 1. RAM writes store the full word. OOR writes are discarded.
- OOR reads return 32'h0. Any cycle whose address decodes OOR sets err_oor, whether a read or a write (mem_wr_en = 0 counts as a read).
- Read-during-write to the same RAM word returns the OLD contents. The new value is visible on the next cycle's read. The same rule applies to TOHOST and SCRATCH.
- Cycle counter:
  - 64-bit, cleared by Reset, increments by 1 every cycle thereafter.
  - Wraps from 2^64-1 to 0 without flagging.
  - The value returned is the count before that edge's increment.
- halt is informational only. RAM and registers keep accepting accesses after halt = 1. halt clears only on Reset.
- RAM contents are not reset. A bench must preload them via hierarchical $readmemh when it needs initial contents.

## Timing
- Read latency is 1 cycle: address at edge N, data valid on mem_rd_data after edge N.
- Write commit is at edge N. A read of the same address launched at edge N+1 returns the new data after edge N+1.
- Priority on mem_rd_data: Reset > mem_rst > normal read.
  - mem_rst = 1 at edge N forces mem_rd_data to 0 after edge N.
  - mem_rst does not block a simultaneous write, does not affect err_oor, and does not load hi_snap.
- Reset = 1 at an edge: mem_rd_data, halt, tohost, err_oor, cycle, hi_snap and SCRATCH all go to 0.
  - Any write presented in the same cycle is discarded, including RAM writes.
  - Reset asserted mid-stream takes effect at that edge. The first post-reset read returns data one edge after Reset deasserts.
- Output reset values: mem_rd_data 0, halt 0, tohost 0, err_oor 0.
- There are no combinational paths from inputs to outputs. All outputs are registers.

## Test plan
- Back-to-back access: write 0xDEADBEEF to 0x0000_0010 at edge 1, read 0x10 at edge 2. Required: mem_rd_data = 0xDEADBEEF after edge 2. Reading 0x13 returns the same word.
- Read-during-write: preload word 4 = 0x1111_1111, then write 0x2222_2222 to 0x10 while reading 0x10. Required: 0x1111_1111 that cycle, then 0x2222_2222 on the next read.
- Mailbox: write 0x0000_0001 to 0x8000_0000. Required: halt = 1 and tohost = 1 after that edge. A later RAM write still lands. Reset then clears halt and tohost.
- Cycle snapshot: after Reset, run 10 idle cycles, read CYCLE_LO, then CYCLE_HI. Required: LO = 10 and HI = 0. With the counter forced to 0xFFFF_FFFF, reading LO then HI returns 0xFFFF_FFFF then 0. A HI read alone shows the last snapshot.
- OOR and mem_rst, with DEPTH_WORDS = 1024:
  - Read 0x0000_1000 → mem_rd_data 0 and err_oor = 1.
  - A write there leaves RAM unchanged.
  - mem_rst asserted during a valid read → mem_rd_data 0 that cycle.
- Reset mid-operation: assert Reset on the same edge as a write to 0x20 of 0xABCD. Required: the write is discarded (word 8 keeps its prior value), and all outputs and SCRATCH read 0.

Source files
------------

// File: rtl/toast_data_mem.sv
// toast_data_mem: data-side memory responder for the Toast RV32I core.
// A word-organised RAM plus a four-register MMIO window (tohost mailbox,
// 64-bit cycle counter with hi-half snapshot, scratch). Read data is
// registered, so it appears one cycle after the address.
module toast_data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_en,
  input  logic        mem_rst,
  output logic [31:0] mem_rd_data,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        err_oor
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] OFF_TOHOST   = 2'd0;
  localparam logic [1:0] OFF_CYCLE_LO = 2'd1;
  localparam logic [1:0] OFF_CYCLE_HI = 2'd2;
  localparam logic [1:0] OFF_SCRATCH  = 2'd3;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [63:0]   cycle;
  logic [31:0]   hi_snap;
  logic [31:0]   scratch;

  logic          is_ram;
  logic          is_mmio;
  logic          is_oor;
  logic [AW-1:0] word_idx;
  logic [1:0]    reg_off;
  logic [31:0]   rd_next;
  logic          unused_addr_bits;

  // A RAM hit means every address bit above the word index is zero.
  assign is_ram           = (mem_addr[31:AW+2] == '0);
  assign is_mmio          = (mem_addr[31:4] == MMIO_BASE[31:4]);
  assign is_oor           = !is_ram && !is_mmio;
  assign word_idx         = mem_addr[AW+1:2];
  assign reg_off          = mem_addr[3:2];
  assign unused_addr_bits = ^mem_addr[1:0];

  // Read mux: data for the address presented this cycle, pre-edge state.
  always_comb begin
    rd_next = '0;
    if (is_ram) begin
      rd_next = ram[word_idx];
    end else if (is_mmio) begin
      case (reg_off)
        OFF_TOHOST:   rd_next = tohost;
        OFF_CYCLE_LO: rd_next = cycle[31:0];
        OFF_CYCLE_HI: rd_next = hi_snap;
        OFF_SCRATCH:  rd_next = scratch;
        default:      rd_next = '0;
      endcase
    end
  end

  // RAM array write port; contents are never reset, but a write coincident
  // with Reset is dropped.
  always_ff @(posedge Clk) begin
    if (!Reset && mem_wr_en && is_ram) begin
      ram[word_idx] <= mem_wr_data;
    end
  end

  // Read-data register, MMIO registers, cycle counter and sticky flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_rd_data <= '0;
      halt        <= 1'b0;
      tohost      <= '0;
      err_oor     <= 1'b0;
      cycle       <= '0;
      hi_snap     <= '0;
      scratch     <= '0;
    end else begin
      cycle <= cycle + 64'd1;

      if (mem_rst) begin
        mem_rd_data <= '0;
      end else begin
        mem_rd_data <= rd_next;
      end

      // The hi half is captured alongside a LO read so a LO/HI pair is coherent.
      if (is_mmio && reg_off == OFF_CYCLE_LO && !mem_rst) begin
        hi_snap <= cycle[63:32];
      end

      if (is_oor) begin
        err_oor <= 1'b1;
      end

      if (mem_wr_en && is_mmio) begin
        case (reg_off)
          OFF_TOHOST: begin
            tohost <= mem_wr_data;
            halt   <= 1'b1;
          end
          OFF_SCRATCH: scratch <= mem_wr_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_toast_data_mem.sv
// Self-checking bench for toast_data_mem: directed scenarios followed by
// randomized traffic, checked against a behavioural model of the memory map.
module tb_toast_data_mem;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] MMIO  = 32'h8000_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_en;
  logic        mem_rst;
  logic [31:0] mem_rd_data;
  logic        halt;
  logic [31:0] tohost;
  logic        err_oor;

  int checks   = 0;
  int failures = 0;

  toast_data_mem #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MMIO)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rst     (mem_rst),
    .mem_rd_data (mem_rd_data),
    .halt        (halt),
    .tohost      (tohost),
    .err_oor     (err_oor)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  bit [31:0]       m_ram [int];
  bit [31:0]       m_tohost;
  bit [31:0]       m_scratch;
  bit [31:0]       m_hi;
  bit              m_halt;
  bit              m_err;
  longint unsigned m_cyc;
  bit              cyc_known;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, let the edge happen, then advance the
  // model with the same inputs and compare all outputs.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic we, input logic mr, input logic rs);
    bit          known;
    bit [31:0]   exp;
    int unsigned widx;
    bit          in_ram;
    bit          in_mmio;
    @(negedge Clk);
    mem_addr    = a;
    mem_wr_data = wd;
    mem_wr_en   = we;
    mem_rst     = mr;
    Reset       = rs;
    @(posedge Clk);
    #1;
    known = 1'b1;
    exp   = 32'h0;
    if (rs) begin
      m_halt = 0; m_tohost = 0; m_err = 0; m_cyc = 0; cyc_known = 1;
      m_hi = 0; m_scratch = 0;
    end else begin
      widx    = a >> 2;
      in_ram  = (widx < DEPTH);
      in_mmio = ((a >> 4) == (MMIO >> 4));
      if (in_ram) begin
        if (m_ram.exists(widx)) exp = m_ram[widx];
        else known = 1'b0;
      end else if (in_mmio) begin
        case ((a >> 2) & 3)
          0: exp = m_tohost;
          1: begin
            exp   = m_cyc[31:0];
            known = cyc_known;
            if (!mr) m_hi = m_cyc[63:32];
          end
          2: exp = m_hi;
          default: exp = m_scratch;
        endcase
      end
      if (mr) begin
        exp   = 32'h0;
        known = 1'b1;
      end
      if (!in_ram && !in_mmio) m_err = 1'b1;
      if (we) begin
        if (in_ram) m_ram[widx] = wd;
        else if (in_mmio) begin
          if (((a >> 2) & 3) == 0) begin
            m_tohost = wd;
            m_halt   = 1'b1;
          end else if (((a >> 2) & 3) == 3) begin
            m_scratch = wd;
          end
        end
      end
      m_cyc = m_cyc + 1;
    end
    if (known) check32({tag, ".rd_data"}, mem_rd_data, exp);
    check1({tag, ".halt"}, halt, m_halt);
    check32({tag, ".tohost"}, tohost, m_tohost);
    check1({tag, ".err_oor"}, err_oor, m_err);
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    step(tag, a, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    step(tag, a, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rst(input string tag);
    step(tag, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;

    Reset = 1'b1; mem_addr = '0; mem_wr_data = '0; mem_wr_en = 1'b0; mem_rst = 1'b0;
    m_cyc = 0; cyc_known = 1'b0;

    // Reset state
    rst("reset0");
    rst("reset1");
    check32("reset.rd_data_const", mem_rd_data, 32'h0);

    // Initialise the low RAM words used by the random phase
    for (int i = 0; i < 16; i++) wr("init", i * 4, $urandom);

    // Back-to-back write then read, byte offsets ignored
    wr("b2b_wr", 32'h10, 32'hDEAD_BEEF);
    rd("b2b_rd", 32'h10);
    check32("b2b_const", mem_rd_data, 32'hDEAD_BEEF);
    rd("b2b_rd13", 32'h13);

    // Read-during-write returns old contents
    wr("rdw_pre", 32'h10, 32'h1111_1111);
    wr("rdw_wr", 32'h10, 32'h2222_2222);
    check32("rdw_old", mem_rd_data, 32'h1111_1111);
    rd("rdw_new", 32'h10);
    check32("rdw_new_const", mem_rd_data, 32'h2222_2222);

    // Out of range read and write; 0x1000 must not alias word 0
    rd("oor_rd", 32'h0000_1000);
    check1("oor_flag", err_oor, 1'b1);
    wr("oor_wr", 32'h0000_1000, 32'hFFFF_0000);
    rd("oor_alias", 32'h0);
    rd("oor_top", 32'h0000_0FFC);

    // mem_rst during a valid read
    step("memrst", 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
    check32("memrst_zero", mem_rd_data, 32'h0);
    // mem_rst does not block a write
    step("memrst_wr", 32'h14, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0);
    rd("memrst_wr_rd", 32'h14);

    // Mailbox, scratch and read-during-write on registers
    wr("tohost_wr", MMIO, 32'h1);
    check1("halt_set", halt, 1'b1);
    wr("post_halt_wr", 32'h18, 32'h5A5A_A5A5);
    rd("post_halt_rd", 32'h18);
    wr("tohost_rdw", MMIO, 32'h77);
    rd("tohost_rd", MMIO);
    wr("scratch_wr", MMIO + 12, 32'hCAFE_0001);
    wr("scratch_rdw", MMIO + 12, 32'hCAFE_0002);
    rd("scratch_rd", MMIO + 12);

    // Cycle snapshot after reset
    rst("cyc_reset");
    check1("halt_cleared", halt, 1'b0);
    check32("tohost_cleared", tohost, 32'h0);
    for (int i = 0; i < 10; i++) rd("idle", 32'h0);
    rd("cyc_lo", MMIO + 4);
    check32("cyc_lo_10", mem_rd_data, 32'd10);
    rd("cyc_hi", MMIO + 8);

    // Snapshot of a counter value with a nonzero upper half
    @(negedge Clk);
    force dut.cycle = 64'h0000_0001_2345_6789;
    m_cyc = 64'h0000_0001_2345_6789;
    rd("cyc_lo_forced", MMIO + 4);
    release dut.cycle;
    cyc_known = 1'b0;
    rd("cyc_hi_forced", MMIO + 8);
    check32("cyc_hi_one", mem_rd_data, 32'h1);
    rd("cyc_hi_again", MMIO + 8);
    step("cyc_lo_memrst", MMIO + 4, 32'h0, 1'b0, 1'b1, 1'b0);
    rd("cyc_hi_kept", MMIO + 8);
    rst("cyc_reset2");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
      else if (sel <= 7) a = MMIO + $urandom_range(0, 15);
      else if (sel == 8) begin
        case ($urandom_range(0, 2))
          0: a = 32'h0000_1000 + $urandom_range(0, 255) * 4;
          1: a = MMIO + 32'h10 + $urandom_range(0, 15);
          default: a = 32'hFFFF_FFFC;
        endcase
      end else a = (1020 + $urandom_range(0, 3)) * 4;
      step("rand", a, $urandom, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 59) == 0));
    end

    // Reset coincident with a write: the write is discarded
    wr("mid_pre", 32'h20, 32'h0000_5555);
    wr("mid_scr", MMIO + 12, 32'h1234_5678);
    wr("mid_th", MMIO, 32'h9);
    step("mid_reset", 32'h20, 32'h0000_ABCD, 1'b1, 1'b0, 1'b1);
    rd("mid_rd20", 32'h20);
    check32("mid_kept", mem_rd_data, 32'h0000_5555);
    rd("mid_scratch", MMIO + 12);
    check32("mid_scratch0", mem_rd_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
